// File: rtl/vbw_acc_stage.sv
// Lane-partitioned accumulator: sums a session of packed 64-bit beats lane-wise (1x64/2x32/4x16/8x8).
// Optional macro VBW_ACC_SAT_EN switches per-lane wraparound to unsigned per-lane saturation.
module vbw_acc_stage #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       control,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_co,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [63:0]      acc;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       mode_q;
  logic             co_q;
  logic             accept;
  logic             last_beat;
  logic [64:0]      sum;

  // Byte-granular adder. A byte index whose low bits under the lane mask are
  // zero starts a new lane, so its carry-in is forced to 0. Bit 64 is the
  // carry out of bit 63.
  function automatic logic [64:0] lane_add(input logic [63:0] a,
                                           input logic [63:0] b,
                                           input logic [1:0]  mode);
    logic [2:0]  mask;
    logic [7:0]  c;
    logic [63:0] s;
    logic [8:0]  t;
    logic        prev;
    logic        ci;
    case (mode)
      2'b00:   mask = 3'd7;
      2'b01:   mask = 3'd3;
      2'b10:   mask = 3'd1;
      default: mask = 3'd0;
    endcase
    c    = '0;
    s    = '0;
    prev = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      ci = ((3'(i) & mask) == 3'd0) ? 1'b0 : prev;
      t  = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + {8'd0, ci};
      s[8*i +: 8] = t[7:0];
      c[i] = t[8];
      prev = t[8];
    end
`ifdef VBW_ACC_SAT_EN
    // A lane overflows when its top byte carries out; the top byte of the lane
    // holding byte i is i | mask.
    for (int unsigned i = 0; i < 8; i++) begin
      if (c[3'(i) | mask]) s[8*i +: 8] = '1;
    end
`endif
    return {c[7], s};
  endfunction

  assign sum       = lane_add(acc, in_data, mode_q);
  assign accept    = (state == ACC) && in_valid;
  assign last_beat = (cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = (len == '0) ? OUT : ACC;
        end
      end
      ACC: begin
        in_ready = 1'b1;
        if (in_valid && last_beat) begin
          state_nx = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        busy     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      len_q  <= '0;
      mode_q <= '0;
      co_q   <= 1'b0;
    end else if (state == IDLE && start) begin
      acc    <= '0;
      cnt    <= '0;
      len_q  <= len;
      mode_q <= control;
      co_q   <= 1'b0;
    end else if (accept) begin
      acc <= sum[63:0];
      cnt <= cnt + LEN_W'(1);
      if (mode_q == 2'b00) begin
        co_q <= co_q | sum[64];
      end
    end
  end

  assign out_data = acc;
  assign out_co   = co_q;

endmodule
